// File: rtl/cmp_result_deserializer_pkg.sv
// rtl/cmp_result_deserializer_pkg.sv - shared state encoding and default sizes for the result deserializer
package cmp_result_deserializer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_result_deserializer_if.sv
// rtl/cmp_result_deserializer_if.sv - comparator bit stream in, assembled word handshake out
interface cmp_result_deserializer_if
  import cmp_result_deserializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             bit_vld;
  logic             outp;
  logic             overflw;
  logic             frame_start;
  logic [WIDTH-1:0] word;
  logic             word_vld;
  logic             word_rdy;
  logic             word_ovf;
  logic [CNT_W-1:0] ovf_cnt;
  logic             drop;

  // master: comparator side plus word consumer; slave: the deserializer
  modport master (
    output bit_vld, outp, overflw, frame_start, word_rdy,
    input  word, word_vld, word_ovf, ovf_cnt, drop
  );

  modport slave (
    input  bit_vld, outp, overflw, frame_start, word_rdy,
    output word, word_vld, word_ovf, ovf_cnt, drop
  );

endinterface

// File: rtl/cmp_result_deserializer_sat_counter.sv
// rtl/cmp_result_deserializer_sat_counter.sv - saturating event counter with synchronous clear
module cmp_result_deserializer_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cmp_result_deserializer.sv
// rtl/cmp_result_deserializer.sv - packs serial comparator results LSB-first into words with overflow tracking
module cmp_result_deserializer
  import cmp_result_deserializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    ck,
  input  logic                    rst,
  cmp_result_deserializer_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt;
  logic             sticky;
  logic [WIDTH-1:0] word_q;
  logic             word_vld_q;
  logic             word_ovf_q;
  logic             drop_q;
  logic             out_free;
  logic             bit_ovf;
  logic [CNT_W-1:0] ovf_cnt;

  always_comb begin
    shreg_nxt      = shreg;
    shreg_nxt[cnt] = bus.outp;
  end

  assign out_free = !word_vld_q || bus.word_rdy;
  assign bit_ovf  = bus.bit_vld & bus.overflw;

  // In HOLD the completed word stays in shreg and its overflow flag in sticky.
  always_ff @(posedge ck) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sticky     <= 1'b0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      word_ovf_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (word_vld_q && bus.word_rdy) begin
        word_vld_q <= 1'b0;
      end

      case (state)
        ST_IDLE, ST_SHIFT: begin
          if (bus.frame_start) begin
            state  <= ST_SHIFT;
            shreg  <= {{(WIDTH-1){1'b0}}, bus.outp & bus.bit_vld};
            cnt    <= bus.bit_vld ? CW'(1) : '0;
            sticky <= bit_ovf;
          end else if ((state == ST_SHIFT) && bus.bit_vld) begin
            shreg <= shreg_nxt;
            if (cnt == LAST) begin
              cnt <= '0;
              if (out_free) begin
                word_q     <= shreg_nxt;
                word_ovf_q <= sticky | bus.overflw;
                word_vld_q <= 1'b1;
                sticky     <= 1'b0;
              end else begin
                sticky <= sticky | bus.overflw;
                state  <= ST_HOLD;
              end
            end else begin
              cnt    <= cnt + CW'(1);
              sticky <= sticky | bus.overflw;
            end
          end
        end

        ST_HOLD: begin
          drop_q <= bus.bit_vld;
          if (out_free) begin
            word_q     <= shreg;
            word_ovf_q <= sticky;
            word_vld_q <= 1'b1;
            sticky     <= 1'b0;
            cnt        <= '0;
            state      <= ST_SHIFT;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  cmp_result_deserializer_sat_counter #(
    .CNT_W(CNT_W)
  ) u_ovf_cnt (
    .clk(ck),
    .clr(rst),
    .inc(bit_ovf),
    .cnt(ovf_cnt)
  );

  assign bus.word     = word_q;
  assign bus.word_vld = word_vld_q;
  assign bus.word_ovf = word_ovf_q;
  assign bus.drop     = drop_q;
  assign bus.ovf_cnt  = ovf_cnt;

endmodule

// File: tb/tb_cmp_result_deserializer.sv
// tb/tb_cmp_result_deserializer.sv - directed scoreboard bench for cmp_result_deserializer
module tb_cmp_result_deserializer;
  import cmp_result_deserializer_pkg::*;

  typedef struct packed {
    logic       ovf;
    logic [7:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_drop = 0;
  int   n_acc  = 0;
  exp_t sb[$];
  exp_t e;

  cmp_result_deserializer_if #(.WIDTH(8), .CNT_W(8)) bus ();

  cmp_result_deserializer #(.WIDTH(8), .CNT_W(8)) dut (
    .ck (clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepts are scored just before the edge that performs them.
  task automatic tick();
    if (bus.word_vld && bus.word_rdy) begin
      n_acc++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("word", 32'(bus.word), 32'(e.w));
        check("word_ovf", 32'(bus.word_ovf), 32'(e.ovf));
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (bus.drop) n_drop++;
  endtask

  task automatic send_bit(input logic b, input logic ovf, input logic fs);
    bus.bit_vld     = 1'b1;
    bus.outp        = b;
    bus.overflw     = ovf;
    bus.frame_start = fs;
    tick();
    bus.bit_vld     = 1'b0;
    bus.outp        = 1'b0;
    bus.overflw     = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic [7:0] om, input logic fs0);
    for (int i = 0; i < 8; i++) send_bit(w[i], om[i], (i == 0) ? fs0 : 1'b0);
  endtask

  initial begin
    bus.bit_vld     = 1'b0;
    bus.outp        = 1'b0;
    bus.overflw     = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_rdy    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_word", 32'(bus.word), 32'h0);
    check("rst_word_vld", 32'(bus.word_vld), 32'h0);
    check("rst_word_ovf", 32'(bus.word_ovf), 32'h0);
    check("rst_ovf_cnt", 32'(bus.ovf_cnt), 32'h0);
    check("rst_drop", 32'(bus.drop), 32'h0);

    // first word 0x4D, one-cycle latency
    sb.push_back('{ovf: 1'b0, w: 8'h4D});
    for (int i = 0; i < 7; i++) send_bit(8'h4D >> i, 1'b0, i == 0);
    check("vld_before_last", 32'(bus.word_vld), 32'h0);
    send_bit(1'b0, 1'b0, 1'b0);
    check("vld_latency", 32'(bus.word_vld), 32'h1);
    tick();
    check("vld_after_accept", 32'(bus.word_vld), 32'h0);
    check("no_drop_t1", 32'(n_drop), 32'h0);

    // back-to-back FF (ovf on bit 3) and 00
    sb.push_back('{ovf: 1'b1, w: 8'hFF});
    sb.push_back('{ovf: 1'b0, w: 8'h00});
    send_word(8'hFF, 8'h08, 1'b0);
    check("b2b_first_vld", 32'(bus.word_vld), 32'h1);
    send_word(8'h00, 8'h00, 1'b0);
    check("b2b_second_vld", 32'(bus.word_vld), 32'h1);
    tick();
    check("b2b_accepts", 32'(n_acc), 32'd3);
    check("ovf_cnt_1", 32'(bus.ovf_cnt), 32'd1);

    // output stalled: second word parks in HOLD, three bits dropped
    sb.push_back('{ovf: 1'b0, w: 8'h3C});
    sb.push_back('{ovf: 1'b0, w: 8'hA5});
    send_word(8'h3C, 8'h00, 1'b0);
    bus.word_rdy = 1'b0;
    send_word(8'hA5, 8'h00, 1'b0);
    check("state_hold", 32'(dut.state), 32'(ST_HOLD));
    check("hold_word_a", 32'(bus.word), 32'h3C);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
    check("hold_word_stable", 32'(bus.word), 32'h3C);
    check("hold_drops", 32'(n_drop), 32'd3);
    bus.word_rdy = 1'b1;
    tick();
    check("release_vld", 32'(bus.word_vld), 32'h1);
    check("release_word_b", 32'(bus.word), 32'hA5);
    check("release_state", 32'(dut.state), 32'(ST_SHIFT));
    tick();

    // accept and load on the same edge keeps WORD_VLD high
    sb.push_back('{ovf: 1'b0, w: 8'h81});
    sb.push_back('{ovf: 1'b0, w: 8'h7E});
    bus.word_rdy = 1'b0;
    send_word(8'h81, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) bus.word_rdy = 1'b1;
      send_bit(8'h7E >> i, 1'b0, 1'b0);
    end
    check("thru_vld", 32'(bus.word_vld), 32'h1);
    check("thru_word", 32'(bus.word), 32'h7E);
    tick();

    // resync at count 5; discarded overflow must not leak into the word
    sb.push_back('{ovf: 1'b0, w: 8'hB7});
    for (int i = 0; i < 5; i++) send_bit(1'b0, i == 2, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) send_bit(8'hB7 >> i, 1'b0, 1'b0);
    check("resync_vld", 32'(bus.word_vld), 32'h1);
    tick();
    check("resync_no_drop", 32'(n_drop), 32'd3);
    check("ovf_cnt_2", 32'(bus.ovf_cnt), 32'd2);

    // reset mid-word with a pending output
    sb.push_back('{ovf: 1'b0, w: 8'h12});
    bus.word_rdy = 1'b0;
    send_word(8'h12, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("mid_rst_vld", 32'(bus.word_vld), 32'h0);
    check("mid_rst_word", 32'(bus.word), 32'h0);
    check("mid_rst_ovf_cnt", 32'(bus.ovf_cnt), 32'h0);
    check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    bus.word_rdy = 1'b1;
    send_word(8'hFF, 8'h00, 1'b0);
    check("idle_ignore_vld", 32'(bus.word_vld), 32'h0);
    check("idle_ignore_state", 32'(dut.state), 32'(ST_IDLE));
    check("idle_no_drop", 32'(n_drop), 32'd3);

    // overflow counter saturation
    for (int i = 0; i < 300; i++) begin
      send_bit(1'b0, 1'b1, 1'b0);
      if (i == 253) check("ovf_cnt_254", 32'(bus.ovf_cnt), 32'd254);
      if (i == 254) check("ovf_cnt_sat", 32'(bus.ovf_cnt), 32'hFF);
    end
    check("ovf_cnt_hold", 32'(bus.ovf_cnt), 32'hFF);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_result_deserializer.md
Name: cmp_result_deserializer

Overview:
- Downstream stage of the serial flow-comparator FSM.
- Consumes the comparator's per-cycle result bit (OUTP) and overflow flag (OVERFLW).
- Assembles result bits into WIDTH-bit words, LSB first.
- Presents each completed word on a valid/ready output register with a per-word overflow flag, plus a saturating global overflow-event counter.

Parameters:
- WIDTH, 8, result bits per word (>=2)
- CNT_W, 8, width of saturating overflow-event counter

Ports:
- CK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous reset, active-high
- BIT_VLD  input  1  OUTP/OVERFLW valid this cycle
- OUTP  input  1  comparator serial result bit
- OVERFLW  input  1  comparator overflow flag for this bit
- FRAME_START  input  1  word alignment; the current bit, if any, becomes bit 0
- WORD  output  WIDTH  assembled word, bit k = k-th accepted bit
- WORD_VLD  output  1  WORD valid
- WORD_RDY  input  1  consumer accepts WORD when WORD_VLD & WORD_RDY
- WORD_OVF  output  1  OVERFLW seen on any bit of WORD
- OVF_CNT  output  CNT_W  count of BIT_VLD&OVERFLW events, saturating
- DROP  output  1  one-cycle pulse: a valid bit was discarded

Behaviour:
- Reset (RST=1 at edge):
  - state=IDLE; shift reg, bit count, sticky ovf = 0.
  - WORD=0, WORD_VLD=0, WORD_OVF=0, OVF_CNT=0, DROP=0.
  - Applies mid-operation: partial word and pending output are discarded; WORD_VLD is low after that edge.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - BIT_VLD without FRAME_START is ignored and does not pulse DROP.
  - FRAME_START: go to SHIFT. If BIT_VLD is also high, the bit is stored as bit 0 and count=1; otherwise count=0.
- SHIFT, BIT_VLD:
  - OUTP is written to shreg[count]; count increments.
  - sticky_ovf |= OVERFLW.
- SHIFT, FRAME_START (any count): resync.
  - Partial word is discarded and sticky_ovf cleared.
  - A bit accompanying FRAME_START becomes bit 0 (count=1, sticky=OVERFLW); otherwise count=0.
  - No DROP pulse for the discarded partial word.
- Word completion: BIT_VLD with count=WIDTH-1 (and no FRAME_START).
  - The output register is free if WORD_VLD=0 or WORD_RDY=1 this cycle.
  - Output free: next edge loads WORD = shreg with the final bit, WORD_OVF = sticky|OVERFLW, WORD_VLD=1. Count and sticky clear; stay in SHIFT, so back-to-back words need no gap.
  - Output not free: go to HOLD holding the complete word and its ovf flag.
- HOLD:
  - Waits until WORD_VLD=0 or WORD_RDY=1, then loads the output register on that edge and goes to SHIFT with count=0.
  - Every BIT_VLD cycle in HOLD discards the bit and pulses DROP the next cycle, including the cycle the hold releases.
  - FRAME_START in HOLD is ignored.
- Latency: last bit at edge t gives WORD_VLD=1 after edge t (visible cycle t+1) when output is free.
- Output handshake:
  - WORD and WORD_OVF are stable while WORD_VLD & !WORD_RDY.
  - WORD_VLD clears after an accept edge unless a new word loads on the same edge. Simultaneous accept+load is full throughput, with no bubble.
- OVF_CNT:
  - +1 on every cycle with BIT_VLD & OVERFLW in any state, including dropped bits and IDLE.
  - Holds at 2^CNT_W-1; cleared only by RST.
- Count width is clog2(WIDTH); count never exceeds WIDTH-1.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_HOLD=2'd2; default WIDTH/CNT_W.
- One natural sub-module: sat_counter (CNT_W, inc, saturate, sync clear) for OVF_CNT.
- Shift/FSM/output register stay in the top module.

Test Plan (WIDTH=8, CNT_W=8):
- Reset, then FRAME_START+BIT_VLD with bits 1,0,1,1,0,0,1,0 over 8 consecutive cycles, OVERFLW=0, WORD_RDY=1 → WORD=8'h4D, WORD_VLD high 1 cycle after the 8th bit, WORD_OVF=0, DROP never.
- Two back-to-back words (8'hFF then 8'h00), WORD_RDY=1, OVERFLW=1 on bit 3 of the first word only → two consecutive accepts with no bubble; WORD_OVF=1 then 0; OVF_CNT=1.
- WORD_RDY=0 while the 2nd word completes, then 3 more BIT_VLD cycles, then WORD_RDY=1 → state HOLD; WORD stable at the first value; 3 DROP pulses; 2nd word is presented right after the first is accepted.
- FRAME_START asserted at count=5 with bit=1 → partial word discarded; next 7 bits complete a word whose bit0=1; no DROP.
- RST asserted at count=4 with WORD_VLD=1 → WORD_VLD=0, OVF_CNT=0, WORD=0 after the edge; BIT_VLD without FRAME_START is ignored.
- 300 cycles of BIT_VLD=1, OVERFLW=1 → OVF_CNT saturates at 8'hFF and stays there.
